// File: rtl/square_wave_sequencer_pkg.sv
// square_wave_pkg: shared state encoding and default widths for the square-wave sequencer.
package square_wave_pkg;

    localparam int CNT_W_DEF    = 16;
    localparam int NPULSE_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/square_wave_sequencer_if.sv
// square_wave_sequencer_if: config handshake, stop request and waveform/status outputs.
interface square_wave_sequencer_if
    import square_wave_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int NPULSE_W = NPULSE_W_DEF
) ();

    logic                cfg_valid;
    logic                cfg_ready;
    logic [CNT_W-1:0]    cfg_high;
    logic [CNT_W-1:0]    cfg_low;
    logic [NPULSE_W-1:0] cfg_pulses;
    logic                stop;
    logic                signal;
    logic                busy;
    logic                done;
    logic [NPULSE_W-1:0] pulses_left;

    modport master (
        output cfg_valid, cfg_high, cfg_low, cfg_pulses, stop,
        input  cfg_ready, signal, busy, done, pulses_left
    );

    modport slave (
        input  cfg_valid, cfg_high, cfg_low, cfg_pulses, stop,
        output cfg_ready, signal, busy, done, pulses_left
    );

endinterface

// File: rtl/square_wave_sequencer_phase_counter.sv
// phase_counter: loadable down-counter with a registered terminal-count flag.
module phase_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    // tc is computed from the value being written so it is valid the same cycle cnt reaches 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            tc  <= 1'b0;
        end else if (load) begin
            cnt <= load_val;
            tc  <= (load_val == '0);
        end else if (en && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            tc  <= (cnt == CNT_W'(1));
        end
    end

endmodule

// File: rtl/square_wave_sequencer.sv
// square_wave_sequencer: accepts a high/low/pulse-count config and plays a cycle-exact square wave.
module square_wave_sequencer
    import square_wave_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int NPULSE_W = NPULSE_W_DEF
) (
    input logic                     clk,
    input logic                     rst_n,
    square_wave_sequencer_if.slave  bus
);

    state_t              state, state_n;
    logic [CNT_W-1:0]    h_len, h_n, l_len, l_n, load_val;
    logic [NPULSE_W-1:0] p_cfg, p_n, pl, pl_n;
    logic                stop_pend, sp_n, done_n, load, en, tc, fin;
    logic                sig_r, busy_r, done_r;

    phase_counter #(.CNT_W(CNT_W)) u_phase (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .en       (en),
        .load_val (load_val),
        .tc       (tc)
    );

    always_comb begin
        state_n  = state;
        h_n      = h_len;
        l_n      = l_len;
        p_n      = p_cfg;
        pl_n     = pl;
        sp_n     = stop_pend;
        done_n   = 1'b0;
        load     = 1'b0;
        en       = 1'b0;
        load_val = '0;
        fin      = stop_pend | bus.stop | (p_cfg != '0 && pl == NPULSE_W'(1));
        case (state)
            IDLE: begin
                if (bus.cfg_valid) begin
                    state_n  = HIGH;
                    h_n      = (bus.cfg_high == '0) ? CNT_W'(1) : bus.cfg_high;
                    l_n      = (bus.cfg_low == '0) ? CNT_W'(1) : bus.cfg_low;
                    p_n      = bus.cfg_pulses;
                    pl_n     = bus.cfg_pulses;
                    sp_n     = 1'b0;
                    load     = 1'b1;
                    load_val = h_n - CNT_W'(1);
                end
            end
            HIGH: begin
                sp_n = stop_pend | bus.stop;
                if (tc) begin
                    state_n  = LOW;
                    load     = 1'b1;
                    load_val = l_len - CNT_W'(1);
                end else begin
                    en = 1'b1;
                end
            end
            LOW: begin
                sp_n = stop_pend | bus.stop;
                if (tc && fin) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                    pl_n    = '0;
                    sp_n    = 1'b0;
                end else if (tc) begin
                    state_n  = HIGH;
                    load     = 1'b1;
                    load_val = h_len - CNT_W'(1);
                    pl_n     = (p_cfg != '0) ? pl - NPULSE_W'(1) : pl;
                end else begin
                    en = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            h_len     <= '0;
            l_len     <= '0;
            p_cfg     <= '0;
            pl        <= '0;
            stop_pend <= 1'b0;
            sig_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state     <= state_n;
            h_len     <= h_n;
            l_len     <= l_n;
            p_cfg     <= p_n;
            pl        <= pl_n;
            stop_pend <= sp_n;
            sig_r     <= (state_n == HIGH);
            busy_r    <= (state_n != IDLE);
            done_r    <= done_n;
        end
    end

    assign bus.cfg_ready   = (state == IDLE);
    assign bus.signal      = sig_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.pulses_left = pl;

endmodule

// File: tb/tb_square_wave_sequencer.sv
// tb_square_wave_sequencer: directed literal checks plus randomized run against a timing-arithmetic model.
module tb_square_wave_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    square_wave_sequencer_if #(.CNT_W(16), .NPULSE_W(8)) bus ();

    square_wave_sequencer #(.CNT_W(16), .NPULSE_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Model: a run is described by its start-relative cycle index t; all outputs follow from t, H, L, P.
    bit m_ok = 0, m_run = 0, m_stop = 0, m_done = 0, stp;
    int m_t = 0, m_h = 1, m_l = 1, m_p = 0, per;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_ok = 1; m_run = 0; m_done = 0; m_stop = 0;
        end else if (!m_run) begin
            m_done = 0;
            if (bus.cfg_valid) begin
                m_run = 1; m_t = 0; m_stop = 0;
                m_h = (bus.cfg_high == 0) ? 1 : int'(bus.cfg_high);
                m_l = (bus.cfg_low == 0) ? 1 : int'(bus.cfg_low);
                m_p = int'(bus.cfg_pulses);
            end
        end else begin
            per = m_h + m_l;
            stp = m_stop | bus.stop;
            m_done = 0;
            if (m_t % per == per - 1 && (stp || (m_p != 0 && m_t / per + 1 == m_p))) begin
                m_run = 0; m_done = 1;
            end else begin
                m_t++; m_stop = stp;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("signal", 32'(bus.signal), 32'(m_run && (m_t % (m_h + m_l)) < m_h));
            chk("busy", 32'(bus.busy), 32'(m_run));
            chk("done", 32'(bus.done), 32'(m_done));
            chk("cfg_ready", 32'(bus.cfg_ready), 32'(!m_run));
            chk("pulses_left", 32'(bus.pulses_left),
                (m_run && m_p != 0) ? 32'(m_p - m_t / (m_h + m_l)) : 32'd0);
        end
    end

    task automatic cfg(input int h, input int l, input int p);
        bus.cfg_valid  = 1'b1;
        bus.cfg_high   = 16'(h);
        bus.cfg_low    = 16'(l);
        bus.cfg_pulses = 8'(p);
    endtask

    logic [9:0] exp_sig;
    logic [14:0] sig_tr, done_tr;

    initial begin
        bus.cfg_valid = 0; bus.cfg_high = 0; bus.cfg_low = 0; bus.cfg_pulses = 0; bus.stop = 0;
        repeat (3) @(negedge clk);
        chk("rst_signal", 32'(bus.signal), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_ready", 32'(bus.cfg_ready), 1);
        chk("rst_pulses_left", 32'(bus.pulses_left), 0);
        rst_n = 1;
        @(negedge clk);
        // H=3 L=2 P=2, then back-to-back H=1 L=1 P=1 accepted in the done cycle
        cfg(3, 2, 2);
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            sig_tr[i] = bus.signal;
            done_tr[i] = bus.done;
            if (i == 1) chk("t2_pl_first", 32'(bus.pulses_left), 2);
            if (i == 6) chk("t2_pl_second", 32'(bus.pulses_left), 1);
            bus.cfg_valid = 1'b0;
            if (i == 11) cfg(1, 1, 1);
        end
        exp_sig = 10'b1110011100;
        for (int i = 1; i <= 10; i++) chk("t2_signal", 32'(sig_tr[i]), 32'(exp_sig[10 - i]));
        chk("t2_done_early", 32'(done_tr[10]), 0);
        chk("t2_done", 32'(done_tr[11]), 1);
        chk("t5_signal_next", 32'(sig_tr[12]), 1);
        chk("t5_done_clear", 32'(done_tr[12]), 0);
        chk("t5_low", 32'(sig_tr[13]), 0);
        chk("t5_done", 32'(done_tr[14]), 1);
        // zero lengths clamp to one cycle each
        repeat (2) @(negedge clk);
        cfg(0, 0, 1);
        @(negedge clk); chk("t3_high", 32'(bus.signal), 1); bus.cfg_valid = 0;
        @(negedge clk); chk("t3_low", 32'(bus.signal), 0); chk("t3_busy", 32'(bus.busy), 1);
        @(negedge clk); chk("t3_done", 32'(bus.done), 1); chk("t3_idle", 32'(bus.busy), 0);
        // continuous run stopped in the 3rd high cycle of period 2
        @(negedge clk);
        cfg(4, 4, 0);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            bus.cfg_valid = 0;
            if (i == 5) chk("t4_pl_cont", 32'(bus.pulses_left), 0);
            if (i == 12) chk("t4_high_done", 32'(bus.signal), 1);
            if (i == 16) begin chk("t4_low_last", 32'(bus.signal), 0); chk("t4_busy_last", 32'(bus.busy), 1); end
            if (i == 17) chk("t4_done", 32'(bus.done), 1);
            if (i == 20) chk("t4_no_more", 32'(bus.signal), 0);
            bus.stop = (i == 11);
        end
        // reset in the middle of a high phase
        cfg(5, 5, 1);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            bus.cfg_valid = 0;
            if (i == 3) begin
                chk("t6_signal", 32'(bus.signal), 0);
                chk("t6_busy", 32'(bus.busy), 0);
                chk("t6_ready", 32'(bus.cfg_ready), 1);
                rst_n = 1;
            end
            if (i > 3) chk("t6_no_done", 32'(bus.done), 0);
            if (i == 2) rst_n = 0;
        end
        repeat (4000) begin
            @(negedge clk);
            bus.cfg_valid  = ($urandom_range(0, 3) == 0);
            bus.cfg_high   = 16'($urandom_range(0, 6));
            bus.cfg_low    = 16'($urandom_range(0, 6));
            bus.cfg_pulses = 8'($urandom_range(0, 4));
            bus.stop       = ($urandom_range(0, 19) == 0);
            rst_n          = ($urandom_range(0, 299) != 0);
        end
        bus.cfg_valid = 0; bus.stop = 0; rst_n = 1;
        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
